// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the memory-slave FSM state type.
// Imported by the memory slave, its bus interface users and the bench.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int unsigned WAIT_STATES_MAX = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slv_state_e;

    // NONSEQ and SEQ are the only transfer types that carry a data phase.
    function automatic logic is_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_mem_slave_if.sv
// AHB-Lite responder-side signal bundle for one slave port.
// The master modport drives the address/data phases; the slave modport answers.
interface ahb_mem_slave_if;

    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic        hready_in;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    // Handshake: an address phase (htrans NONSEQ/SEQ) is taken at a rising edge only
    // when hready_in and hreadyout are both 1; its data phase completes at the first
    // later edge with hreadyout=1, and hrdata/hresp are valid at that edge.
    modport master (
        output haddr, hwrite, htrans, hready_in, hwdata,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  haddr, hwrite, htrans, hready_in, hwdata,
        output hreadyout, hresp, hrdata
    );

endinterface

// File: rtl/ahb_mem_array.sv
// Word-per-address storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module ahb_mem_array #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    localparam int DEPTH = 1 << IDX_W;

    logic [31:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory responder: region decode, programmable wait states, two-cycle
// ERROR response, and write-to-read forwarding for back-to-back same-word access.
module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter logic [31:0] ADDR_MASK   = 32'hF000_0000,
    parameter int          IDX_W       = 8,
    parameter int          WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hresetn,
    ahb_mem_slave_if.slave    bus,
    output slv_state_e        dbg_state
);

    localparam logic [2:0] WCNT_INIT = 3'(WAIT_STATES);

    slv_state_e       state_q, state_d;
    logic [2:0]       wcnt_q, wcnt_d;
    logic             wr_q, wr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      hrdata_q, hrdata_d;

    logic             hreadyout_s;
    logic             hresp_s;
    logic             hit;
    logic             accept;
    logic [IDX_W-1:0] a_idx;
    logic             mem_we;
    logic             fwd;
    logic [31:0]      mem_rdata;

    // Outputs decode only registered state, so nothing on the bus inputs reaches them.
    always_comb begin
        hreadyout_s = 1'b1;
        hresp_s     = HRESP_OKAY;
        case (state_q)
            ST_DATA: hreadyout_s = (wcnt_q == 3'd0);
            ST_ERR1: begin
                hreadyout_s = 1'b0;
                hresp_s     = HRESP_ERROR;
            end
            ST_ERR2: hresp_s = HRESP_ERROR;
            default: ;
        endcase
    end

    assign hit    = ((bus.haddr & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
    assign a_idx  = bus.haddr[IDX_W-1:0];
    assign accept = bus.hready_in && hreadyout_s && is_active(bus.htrans);
    assign mem_we = (state_q == ST_DATA) && (wcnt_q == 3'd0) && wr_q;
    // A read taking its address at the edge a same-word write lands must see the new word.
    assign fwd    = mem_we && (idx_q == a_idx);

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        wr_d     = wr_q;
        idx_d    = idx_q;
        hrdata_d = hrdata_q;
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if ((state_q == ST_DATA) && (wcnt_q != 3'd0)) begin
            wcnt_d = wcnt_q - 3'd1;
        end else if (accept) begin
            wr_d  = bus.hwrite;
            idx_d = a_idx;
            if (hit) begin
                state_d = ST_DATA;
                wcnt_d  = WCNT_INIT;
                if (!bus.hwrite) begin
                    hrdata_d = fwd ? bus.hwdata : mem_rdata;
                end
            end else begin
                state_d = ST_ERR1;
                wcnt_d  = 3'd0;
            end
        end else begin
            state_d = ST_IDLE;
            wcnt_d  = 3'd0;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= 3'd0;
            wr_q     <= 1'b0;
            idx_q    <= '0;
            hrdata_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            wr_q     <= wr_d;
            idx_q    <= idx_d;
            hrdata_q <= hrdata_d;
        end
    end

    ahb_mem_array #(.IDX_W(IDX_W)) u_mem (
        .clk   (hclk),
        .we    (mem_we),
        .waddr (idx_q),
        .wdata (bus.hwdata),
        .raddr (a_idx),
        .rdata (mem_rdata)
    );

    assign bus.hreadyout = hreadyout_s;
    assign bus.hresp     = hresp_s;
    assign bus.hrdata    = hrdata_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench for ahb_mem_slave: three instances (0, 2 and 3 wait states) share
// one pipelined AHB driver; sel routes transfers to exactly one of them.
module tb_ahb_mem_slave;
  import ahb_pkg::*;

  // ---------------- clock / reset ----------------
  logic hclk = 1'b0;
  logic hresetn;
  always #5 hclk = ~hclk;

  ahb_mem_slave_if bus0 ();
  ahb_mem_slave_if bus2 ();
  ahb_mem_slave_if bus3 ();
  slv_state_e st0, st2, st3;

  logic [31:0] d_haddr;
  logic        d_hwrite;
  logic [1:0]  d_htrans;
  logic [31:0] d_hwdata;
  int          sel;

  assign bus0.haddr = d_haddr;
  assign bus2.haddr = d_haddr;
  assign bus3.haddr = d_haddr;
  assign bus0.hwrite = d_hwrite;
  assign bus2.hwrite = d_hwrite;
  assign bus3.hwrite = d_hwrite;
  assign bus0.hwdata = d_hwdata;
  assign bus2.hwdata = d_hwdata;
  assign bus3.hwdata = d_hwdata;
  assign bus0.htrans = (sel == 0) ? d_htrans : HTRANS_IDLE;
  assign bus2.htrans = (sel == 2) ? d_htrans : HTRANS_IDLE;
  assign bus3.htrans = (sel == 3) ? d_htrans : HTRANS_IDLE;
  assign bus0.hready_in = bus0.hreadyout;
  assign bus2.hready_in = bus2.hreadyout;
  assign bus3.hready_in = bus3.hreadyout;

  logic        cur_ready;
  logic        cur_resp;
  logic [31:0] cur_rdata;
  always_comb begin
    cur_ready = bus3.hreadyout;
    cur_resp  = bus3.hresp;
    cur_rdata = bus3.hrdata;
    case (sel)
      0: begin cur_ready = bus0.hreadyout; cur_resp = bus0.hresp; cur_rdata = bus0.hrdata; end
      2: begin cur_ready = bus2.hreadyout; cur_resp = bus2.hresp; cur_rdata = bus2.hrdata; end
      default: ;
    endcase
  end

  ahb_mem_slave dut0 (.hclk(hclk), .hresetn(hresetn), .bus(bus0.slave), .dbg_state(st0));
  ahb_mem_slave #(.WAIT_STATES(2)) dut2 (.hclk(hclk), .hresetn(hresetn), .bus(bus2.slave), .dbg_state(st2));
  ahb_mem_slave #(.WAIT_STATES(3)) dut3 (.hclk(hclk), .hresetn(hresetn), .bus(bus3.slave), .dbg_state(st3));

  // ---------------- scoreboard state ----------------
  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_rd[$];
  logic        got_resp[$];
  logic        got_first[$];
  int          got_waits[$];

  logic [31:0] v_addr[16];
  logic        v_wr[16];
  logic [1:0]  v_trans[16];
  logic [31:0] v_wd[16];

  // ---------------- driver tasks ----------------
  task automatic set_vec(input int k, input logic [1:0] t, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    v_trans[k] = t;
    v_wr[k]    = w;
    v_addr[k]  = a;
    v_wd[k]    = d;
  endtask

  // Pipelined master: entry i is presented until consumed by a ready edge; per data
  // phase it records first-cycle hresp, wait count, final hresp and hrdata.
  task automatic run_seq(input int n, output int cycles);
    int i, cyc, waits;
    bit pend, first;
    logic pend_wr;
    logic [31:0] pend_wd;
    i = 0; cyc = 0; waits = 0; pend = 0; first = 0; pend_wr = 1'b0; pend_wd = 32'h0;
    got_rd.delete(); got_resp.delete(); got_first.delete(); got_waits.delete();
    while ((i < n || pend) && cyc < 200) begin
      if (i < n) begin
        d_htrans = v_trans[i]; d_haddr = v_addr[i]; d_hwrite = v_wr[i];
      end else begin
        d_htrans = HTRANS_IDLE; d_hwrite = 1'b0;
      end
      d_hwdata = (pend && pend_wr) ? pend_wd : 32'h0;
      @(negedge hclk);
      if (pend && first) begin
        got_first.push_back(cur_resp);
        first = 0;
      end
      if (pend && !cur_ready) waits++;
      if (cur_ready) begin
        if (pend) begin
          got_rd.push_back(cur_rdata);
          got_resp.push_back(cur_resp);
          got_waits.push_back(waits);
        end
        pend = 0;
        if (i < n) begin
          if (v_trans[i][1]) begin
            pend = 1; first = 1; waits = 0;
            pend_wr = v_wr[i]; pend_wd = v_wd[i];
          end
          i++;
        end
      end
      @(posedge hclk); #1;
      cyc++;
    end
    d_htrans = HTRANS_IDLE;
    d_hwrite = 1'b0;
    n_assert++;
    if (cyc >= 200) begin
      $display("FAIL run_seq_timeout: cycles=%0d, required < 200", cyc);
      n_fail++;
    end
    cycles = cyc;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    hresetn = 1'b0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    n_assert++; if (bus0.hreadyout !== 1'b1) begin $display("FAIL rst_ready0: got %b exp 1", bus0.hreadyout); n_fail++; end
    n_assert++; if (bus0.hresp !== 1'b0) begin $display("FAIL rst_resp0: got %b exp 0", bus0.hresp); n_fail++; end
    n_assert++; if (bus0.hrdata !== 32'h0) begin $display("FAIL rst_rdata0: got %h exp 0", bus0.hrdata); n_fail++; end
    n_assert++; if (bus2.hreadyout !== 1'b1) begin $display("FAIL rst_ready2: got %b exp 1", bus2.hreadyout); n_fail++; end
    n_assert++; if (bus2.hresp !== 1'b0) begin $display("FAIL rst_resp2: got %b exp 0", bus2.hresp); n_fail++; end
    n_assert++; if (bus3.hrdata !== 32'h0) begin $display("FAIL rst_rdata3: got %h exp 0", bus3.hrdata); n_fail++; end
    n_assert++; if (st0 !== ST_IDLE) begin $display("FAIL rst_state0: got %0d exp %0d", st0, ST_IDLE); n_fail++; end
    hresetn = 1'b1;
    @(posedge hclk); #1;
  endtask

  task automatic test_single();
    int cyc;
    sel = 0;
    set_vec(0, HTRANS_NONSEQ, 1'b1, 32'h8000_0000, 32'h24);
    set_vec(1, HTRANS_IDLE,   1'b0, 32'h0,         32'h0);
    set_vec(2, HTRANS_NONSEQ, 1'b0, 32'h8000_0000, 32'h0);
    run_seq(3, cyc);
    n_assert++; if (got_rd.size() !== 2) begin $display("FAIL single_phases: got %0d exp 2", got_rd.size()); n_fail++; end
    n_assert++; if (got_rd[1] !== 32'h24) begin $display("FAIL single_rdata: got %h exp 00000024", got_rd[1]); n_fail++; end
    n_assert++; if (got_resp[0] !== 1'b0 || got_resp[1] !== 1'b0) begin $display("FAIL single_resp: got %b%b exp 00", got_resp[0], got_resp[1]); n_fail++; end
    n_assert++; if (got_waits[0] + got_waits[1] !== 0) begin $display("FAIL single_waits: got %0d exp 0", got_waits[0] + got_waits[1]); n_fail++; end
    n_assert++; if (cyc !== 4) begin $display("FAIL single_cycles: got %0d exp 4", cyc); n_fail++; end
  endtask

  task automatic test_error();
    int cyc;
    sel = 0;
    set_vec(0, HTRANS_NONSEQ, 1'b1, 32'h4000_0000, 32'hFF);
    set_vec(1, HTRANS_NONSEQ, 1'b0, 32'h8000_0000, 32'h0);
    set_vec(2, HTRANS_NONSEQ, 1'b0, 32'h4000_0004, 32'h0);
    run_seq(3, cyc);
    n_assert++; if (got_first[0] !== 1'b1 || got_waits[0] !== 1) begin $display("FAIL err1_phase: got resp=%b waits=%0d exp resp=1 waits=1", got_first[0], got_waits[0]); n_fail++; end
    n_assert++; if (got_resp[0] !== 1'b1) begin $display("FAIL err2_resp: got %b exp 1", got_resp[0]); n_fail++; end
    n_assert++; if (got_rd[1] !== 32'h24 || got_resp[1] !== 1'b0) begin $display("FAIL err_no_write: got %h/%b exp 00000024/0", got_rd[1], got_resp[1]); n_fail++; end
    n_assert++; if (got_rd[2] !== 32'h24 || got_resp[2] !== 1'b1) begin $display("FAIL err_rd_hold: got %h/%b exp 00000024/1", got_rd[2], got_resp[2]); n_fail++; end
    n_assert++; if (cyc !== 6) begin $display("FAIL err_cycles: got %0d exp 6", cyc); n_fail++; end
  endtask

  task automatic test_burst();
    int cyc, wsum;
    logic [31:0] exp;
    sel = 0;
    set_vec(0, HTRANS_NONSEQ, 1'b1, 32'h8000_0000, 32'hA0A0_0001);
    set_vec(1, HTRANS_SEQ,    1'b1, 32'h8000_0001, 32'hB0B0_0002);
    set_vec(2, HTRANS_SEQ,    1'b1, 32'h8000_0002, 32'hC0C0_0003);
    set_vec(3, HTRANS_SEQ,    1'b1, 32'h8000_0003, 32'hD0D0_0004);
    set_vec(4, HTRANS_NONSEQ, 1'b0, 32'h8000_0000, 32'h0);
    set_vec(5, HTRANS_SEQ,    1'b0, 32'h8000_0001, 32'h0);
    set_vec(6, HTRANS_BUSY,   1'b0, 32'h8000_0002, 32'h0);
    set_vec(7, HTRANS_SEQ,    1'b0, 32'h8000_0002, 32'h0);
    set_vec(8, HTRANS_SEQ,    1'b0, 32'h8000_0003, 32'h0);
    exp_q.push_back(32'hA0A0_0001);
    exp_q.push_back(32'hB0B0_0002);
    exp_q.push_back(32'hC0C0_0003);
    exp_q.push_back(32'hD0D0_0004);
    run_seq(9, cyc);
    for (int k = 4; k < 8; k++) begin
      exp = exp_q.pop_front();
      n_assert++;
      if (got_rd[k] !== exp) begin $display("FAIL burst_rd%0d: got %h exp %h", k - 4, got_rd[k], exp); n_fail++; end
    end
    wsum = 0;
    foreach (got_waits[k]) wsum += got_waits[k];
    n_assert++; if (wsum !== 0) begin $display("FAIL burst_waits: got %0d exp 0", wsum); n_fail++; end
    n_assert++; if (cyc !== 10) begin $display("FAIL burst_cycles: got %0d exp 10", cyc); n_fail++; end
  endtask

  task automatic test_back_to_back();
    int cyc;
    sel = 0;
    set_vec(0, HTRANS_NONSEQ, 1'b1, 32'h8000_0010, 32'h33);
    run_seq(1, cyc);
    set_vec(0, HTRANS_NONSEQ, 1'b1, 32'h8000_0010, 32'h5A);
    set_vec(1, HTRANS_NONSEQ, 1'b0, 32'h8000_0010, 32'h0);
    set_vec(2, HTRANS_IDLE,   1'b0, 32'h0,         32'h0);
    set_vec(3, HTRANS_NONSEQ, 1'b0, 32'h8000_0010, 32'h0);
    run_seq(4, cyc);
    n_assert++; if (got_rd[1] !== 32'h5A) begin $display("FAIL hazard_fwd: got %h exp 0000005a", got_rd[1]); n_fail++; end
    n_assert++; if (got_rd[2] !== 32'h5A) begin $display("FAIL hazard_mem: got %h exp 0000005a", got_rd[2]); n_fail++; end
  endtask

  task automatic test_wait_states();
    int cyc, low;
    sel = 2;
    set_vec(0, HTRANS_NONSEQ, 1'b1, 32'h8000_0007, 32'h0A0A);
    set_vec(1, HTRANS_IDLE,   1'b0, 32'h0,         32'h0);
    set_vec(2, HTRANS_NONSEQ, 1'b0, 32'h8000_0007, 32'h0);
    run_seq(3, cyc);
    n_assert++; if (got_waits[0] !== 2 || got_waits[1] !== 2) begin $display("FAIL ws_waits: got %0d/%0d exp 2/2", got_waits[0], got_waits[1]); n_fail++; end
    n_assert++; if (got_rd[1] !== 32'h0A0A) begin $display("FAIL ws_rdata: got %h exp 00000a0a", got_rd[1]); n_fail++; end
    d_haddr = 32'h8000_0007; d_hwrite = 1'b1; d_htrans = HTRANS_NONSEQ;
    @(negedge hclk);
    @(posedge hclk); #1;
    d_htrans = HTRANS_IDLE; d_hwrite = 1'b0; d_hwdata = 32'h0B0B;
    low = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      if (!bus2.hreadyout) low++;
      n_assert++;
      if (dut2.u_mem.mem[7] !== 32'h0A0A) begin $display("FAIL ws_early_write%0d: got %h exp 00000a0a", k, dut2.u_mem.mem[7]); n_fail++; end
      @(posedge hclk); #1;
    end
    n_assert++; if (low !== 2) begin $display("FAIL ws_low_cycles: got %0d exp 2", low); n_fail++; end
    n_assert++; if (dut2.u_mem.mem[7] !== 32'h0B0B) begin $display("FAIL ws_final_write: got %h exp 00000b0b", dut2.u_mem.mem[7]); n_fail++; end
    d_hwdata = 32'h0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    sel = 3;
    set_vec(0, HTRANS_NONSEQ, 1'b1, 32'h8000_0005, 32'h1111_2222);
    set_vec(1, HTRANS_IDLE,   1'b0, 32'h0,         32'h0);
    set_vec(2, HTRANS_NONSEQ, 1'b0, 32'h8000_0005, 32'h0);
    run_seq(3, cyc);
    n_assert++; if (got_rd[1] !== 32'h1111_2222) begin $display("FAIL rm_pre_read: got %h exp 11112222", got_rd[1]); n_fail++; end
    d_haddr = 32'h8000_0005; d_hwrite = 1'b1; d_htrans = HTRANS_NONSEQ;
    @(negedge hclk);
    @(posedge hclk); #1;
    d_htrans = HTRANS_IDLE; d_hwrite = 1'b0; d_hwdata = 32'hDEAD_BEEF;
    @(posedge hclk); #2;
    hresetn = 1'b0;
    #1;
    n_assert++; if (bus3.hreadyout !== 1'b1) begin $display("FAIL rm_ready: got %b exp 1", bus3.hreadyout); n_fail++; end
    n_assert++; if (bus3.hresp !== 1'b0) begin $display("FAIL rm_resp: got %b exp 0", bus3.hresp); n_fail++; end
    n_assert++; if (bus3.hrdata !== 32'h0) begin $display("FAIL rm_rdata: got %h exp 0", bus3.hrdata); n_fail++; end
    n_assert++; if (st3 !== ST_IDLE) begin $display("FAIL rm_state: got %0d exp %0d", st3, ST_IDLE); n_fail++; end
    @(negedge hclk);
    hresetn = 1'b1;
    d_hwdata = 32'h0;
    @(posedge hclk); #1;
    set_vec(0, HTRANS_NONSEQ, 1'b0, 32'h8000_0005, 32'h0);
    run_seq(1, cyc);
    n_assert++; if (got_rd[0] !== 32'h1111_2222) begin $display("FAIL rm_word_kept: got %h exp 11112222", got_rd[0]); n_fail++; end
    n_assert++; if (got_waits[0] !== 3) begin $display("FAIL rm_waits: got %0d exp 3", got_waits[0]); n_fail++; end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    sel = 0;
    d_haddr = 32'h0; d_hwrite = 1'b0; d_htrans = HTRANS_IDLE; d_hwdata = 32'h0;
    test_reset();
    test_single();
    test_error();
    test_burst();
    test_back_to_back();
    test_wait_states();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
